fifo_wrptr_full: RTL

Write-side pointer and full-flag controller for the asynchronous FIFO; the write-domain counterpart of the read-pointer/empty block. It holds the binary write pointer, drives the FIFO memory write address and enable, and publishes a registered Gray-coded write pointer to the read domain. It also brings the read domain's Gray read pointer across on a two-flop synchronizer and derives full, almost-full, fill level and a sticky overflow flag from it.

---
 rtl/fifo_wrptr_full_if.sv | 28 ++
 rtl/fifo_wrptr_full.sv | 78 +++++++
 2 files changed

// File: rtl/fifo_wrptr_full_if.sv
// Write-side handshake bundle between the async-FIFO write controller and its
// write-domain user / read-domain pointer crossing.
interface fifo_wrptr_full_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic          W_INC;
  logic [PW-1:0] gray_Rptr;
  logic          W_EN;
  logic [AW-1:0] Waddr;
  logic [PW-1:0] gray_Wptr;
  logic          WFULL;
  logic          WAFULL;
  logic [PW-1:0] WLEVEL;
  logic          WOVF;

  modport master (
    output W_INC, gray_Rptr,
    input  W_EN, Waddr, gray_Wptr, WFULL, WAFULL, WLEVEL, WOVF
  );

  modport slave (
    input  W_INC, gray_Rptr,
    output W_EN, Waddr, gray_Wptr, WFULL, WAFULL, WLEVEL, WOVF
  );
endinterface

// File: rtl/fifo_wrptr_full.sv
// Async-FIFO write pointer and full/almost-full/level/overflow controller.
// The read pointer crosses in on a two-flop Gray synchronizer; full is pessimistic.
module fifo_wrptr_full #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  fifo_wrptr_full_if.slave  wif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] AFULL_TH = (PW+1)'(AFULL_LVL);

  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_param_chk
    $error("fifo_wrptr_full: illegal parameter set");
  end

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] gray_wptr_q, gray_wptr_d;
  logic [PW-1:0] rq1_q, rq2_q;
  logic          wovf_q, wovf_d;

  logic [PW-1:0] rbin;
  logic [PW-1:0] wlevel;
  logic          wfull;
  logic          wafull;
  logic          w_en;

  // Everything downstream of the synchronizer sees only rq2_q.
  always_comb begin
    rbin        = gray2bin(rq2_q);
    wfull       = (wptr_q[AW] != rbin[AW]) && (wptr_q[AW-1:0] == rbin[AW-1:0]);
    wlevel      = wptr_q - rbin;
    wafull      = ({1'b0, wlevel} >= AFULL_TH);
    w_en        = wif.W_INC & ~wfull & W_RST;
    wptr_d      = (wif.W_INC && !wfull) ? wptr_q + PW'(1) : wptr_q;
    gray_wptr_d = bin2gray(wptr_d);
    wovf_d      = wovf_q | (wif.W_INC & wfull);
  end

  always_ff @(posedge W_CLK) begin
    if (!W_RST) begin
      wptr_q      <= '0;
      gray_wptr_q <= '0;
      rq1_q       <= '0;
      rq2_q       <= '0;
      wovf_q      <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      gray_wptr_q <= gray_wptr_d;
      rq1_q       <= wif.gray_Rptr;
      rq2_q       <= rq1_q;
      wovf_q      <= wovf_d;
    end
  end

  assign wif.W_EN      = w_en;
  assign wif.Waddr     = wptr_q[AW-1:0];
  assign wif.gray_Wptr = gray_wptr_q;
  assign wif.WFULL     = wfull;
  assign wif.WAFULL    = wafull;
  assign wif.WLEVEL    = wlevel;
  assign wif.WOVF      = wovf_q;
endmodule
